vga_register_panel: RTL and testbench

//  Parametrised successor to the fixed per-register display overlays: draws NUM_CH registers of WIDTH bits

---
 rtl/vga_panel_pkg.sv | 18 +
 rtl/vga_register_panel_if.sv | 18 +
 rtl/vga_panel_hit.sv | 69 ++++++
 rtl/vga_register_panel.sv | 116 +++++++++++
 tb/tb_vga_register_panel.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_panel_pkg.sv
// Shared constants and helpers for the register display panel: coordinate width,
// 3-bit {R,G,B} palette and expansion of a palette entry to 24-bit RGB.
package vga_panel_pkg;

  localparam int unsigned COORD_W = 11;

  typedef logic [2:0] colour_t;

  localparam colour_t COL_OFF  = 3'b000;
  localparam colour_t COL_ONE  = 3'b100;
  localparam colour_t COL_ZERO = 3'b001;
  localparam colour_t COL_HL   = 3'b110;

  function automatic logic [23:0] expand_rgb(input colour_t c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

endpackage

// File: rtl/vga_register_panel_if.sv
// Pixel-side bus of the register panel: register taps and raster position in,
// overlay pixel and its valid flag out.
interface vga_register_panel_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned WIDTH  = 8
);
  import vga_panel_pkg::*;

  logic [NUM_CH*WIDTH-1:0] data_in;
  logic [COORD_W-1:0]      vga_h;
  logic [COORD_W-1:0]      vga_v;
  logic [23:0]             pixel_out;
  logic                    display_on;

  modport master (output data_in, vga_h, vga_v, input pixel_out, display_on);
  modport slave  (input data_in, vga_h, vga_v, output pixel_out, display_on);

endinterface

// File: rtl/vga_panel_hit.sv
// Stage-1 geometry decoder: maps the raster position to a (channel, bit) box
// using parallel range compares, registered with synchronous reset.
module vga_panel_hit
  import vga_panel_pkg::*;
#(
  parameter int unsigned  NUM_CH    = 8,
  parameter int unsigned  WIDTH     = 8,
  parameter logic [10:0]  START_H   = 11'd50,
  parameter logic [10:0]  START_V   = 11'd10,
  parameter int unsigned  ROW_PITCH = 30,
  parameter int unsigned  BIT_PITCH = 20,
  parameter int unsigned  BOX_SIZE  = 16,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] vga_h,
  input  logic [COORD_W-1:0] vga_v,
  output logic               hit,
  output logic [CH_W-1:0]    ch_idx,
  output logic [BIT_W-1:0]   bit_idx
);

  logic             row_hit;
  logic             col_hit;
  logic [CH_W-1:0]  row_sel;
  logic [BIT_W-1:0] col_sel;

  // Compares run in 32 bits so box edges past the 11-bit raster simply never match.
  function automatic logic in_span(input logic [COORD_W-1:0] pos, input int unsigned lo);
    return (32'(pos) >= lo) && (32'(pos) < lo + BOX_SIZE);
  endfunction

  always_comb begin
    row_hit = 1'b0;
    row_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!row_hit && in_span(vga_v, 32'(START_V) + c * ROW_PITCH)) begin
        row_hit = 1'b1;
        row_sel = CH_W'(c);
      end
    end
  end

  always_comb begin
    col_hit = 1'b0;
    col_sel = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (!col_hit && in_span(vga_h, 32'(START_H) + (WIDTH - 1 - b) * BIT_PITCH)) begin
        col_hit = 1'b1;
        col_sel = BIT_W'(b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit     <= 1'b0;
      ch_idx  <= '0;
      bit_idx <= '0;
    end else begin
      hit     <= row_hit && col_hit;
      ch_idx  <= row_sel;
      bit_idx <= col_sel;
    end
  end

endmodule

// File: rtl/vga_register_panel.sv
// Register panel overlay: per-frame snapshot of NUM_CH x WIDTH register taps drawn as
// coloured bit boxes, 2-clock pixel pipeline. Define VGA_REGISTER_PANEL_CHANGE_HL_EN to highlight changed bits.
module vga_register_panel
  import vga_panel_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned WIDTH       = 8,
  parameter logic [10:0] START_H     = 11'd50,
  parameter logic [10:0] START_V     = 11'd10,
  parameter int unsigned ROW_PITCH   = 30,
  parameter int unsigned BIT_PITCH   = 20,
  parameter int unsigned BOX_SIZE    = 16,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_register_panel_if.slave  bus
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (HOLD_FRAMES < 1 || BOX_SIZE > ROW_PITCH || BOX_SIZE > BIT_PITCH) begin : g_bad_params
    $error("vga_register_panel: BOX_SIZE must fit both pitches and HOLD_FRAMES must be >= 1");
  end

  logic             frame_start;
  logic             hit;
  logic [CH_W-1:0]  ch_idx;
  logic [BIT_W-1:0] bit_idx;
  logic [WIDTH-1:0] live [NUM_CH];
  logic [WIDTH-1:0] snap [NUM_CH];
  colour_t          colour;

  assign frame_start = (bus.vga_h == '0) && (bus.vga_v == '0);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      live[c] = bus.data_in[c*WIDTH +: WIDTH];
    end
  end

  vga_panel_hit #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .START_H   (START_H),
    .START_V   (START_V),
    .ROW_PITCH (ROW_PITCH),
    .BIT_PITCH (BIT_PITCH),
    .BOX_SIZE  (BOX_SIZE)
  ) u_hit (
    .clk     (clk),
    .reset   (reset),
    .vga_h   (bus.vga_h),
    .vga_v   (bus.vga_v),
    .hit     (hit),
    .ch_idx  (ch_idx),
    .bit_idx (bit_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) snap[c] <= '0;
    end else if (frame_start) begin
      for (int unsigned c = 0; c < NUM_CH; c++) snap[c] <= live[c];
    end
  end

`ifdef VGA_REGISTER_PANEL_CHANGE_HL_EN
  localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);

  logic [WIDTH-1:0] mask [NUM_CH];
  logic [CNT_W-1:0] cnt  [NUM_CH];

  // Diff is taken against the outgoing snapshot; a fresh change replaces the mask and restarts the hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mask[c] <= '0;
        cnt[c]  <= '0;
      end
    end else if (frame_start) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if ((live[c] ^ snap[c]) != '0) begin
          mask[c] <= live[c] ^ snap[c];
          cnt[c]  <= CNT_W'(HOLD_FRAMES);
        end else if (cnt[c] != '0) begin
          cnt[c] <= cnt[c] - CNT_W'(1);
          if (cnt[c] == CNT_W'(1)) mask[c] <= '0;
        end
      end
    end
  end
`endif

  always_comb begin
    colour = COL_OFF;
    if (hit) begin
      colour = snap[ch_idx][bit_idx] ? COL_ONE : COL_ZERO;
`ifdef VGA_REGISTER_PANEL_CHANGE_HL_EN
      if (mask[ch_idx][bit_idx]) colour = COL_HL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pixel_out  <= '0;
      bus.display_on <= 1'b0;
    end else begin
      bus.pixel_out  <= expand_rgb(colour);
      bus.display_on <= hit;
    end
  end

endmodule

// File: tb/tb_vga_register_panel.sv
// Directed and randomised checks of the register panel against a coordinate-arithmetic
// reference model with a two-deep expected-pixel pipeline.
module tb_vga_register_panel;

  localparam int NUM_CH = 8;
  localparam int WIDTH  = 8;
  localparam int SH     = 50;
  localparam int SV     = 10;
  localparam int RP     = 30;
  localparam int BP     = 20;
  localparam int BOX    = 16;
  localparam int HOLD   = 2;

  localparam logic [24:0] OFF    = 25'h0;
  localparam logic [24:0] RED    = {1'b1, 24'hFF0000};
  localparam logic [24:0] BLUE   = {1'b1, 24'h0000FF};
  localparam logic [24:0] YELLOW = {1'b1, 24'hFFFF00};

`ifdef VGA_REGISTER_PANEL_CHANGE_HL_EN
  localparam bit ANCHOR = 1'b0;
`else
  localparam bit ANCHOR = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_register_panel_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  vga_register_panel #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .START_H     (11'd50),
    .START_V     (11'd10),
    .ROW_PITCH   (RP),
    .BIT_PITCH   (BP),
    .BOX_SIZE    (BOX),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [NUM_CH*WIDTH-1:0] data;
  logic [WIDTH-1:0]        m_snap [NUM_CH];
  logic [WIDTH-1:0]        m_mask [NUM_CH];
  int                      m_cnt  [NUM_CH];
  logic [24:0]             expq   [$];
  string                   tagq   [$];

  function automatic logic [24:0] model_pixel(input int h, input int v);
    int c, k, b;
    if (v < SV || h < SH) return OFF;
    c = (v - SV) / RP;
    k = (h - SH) / BP;
    if ((v - SV) % RP >= BOX || c >= NUM_CH) return OFF;
    if ((h - SH) % BP >= BOX || k >= WIDTH) return OFF;
    b = WIDTH - 1 - k;
    if (m_mask[c][b]) return YELLOW;
    return m_snap[c][b] ? RED : BLUE;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_snap[c] = '0;
      m_mask[c] = '0;
      m_cnt[c]  = 0;
    end
  endtask

  task automatic model_frame();
    logic [WIDTH-1:0] nv;
    for (int c = 0; c < NUM_CH; c++) begin
      nv = data[c*WIDTH +: WIDTH];
`ifdef VGA_REGISTER_PANEL_CHANGE_HL_EN
      if ((nv ^ m_snap[c]) != '0) begin
        m_mask[c] = nv ^ m_snap[c];
        m_cnt[c]  = HOLD;
      end else if (m_cnt[c] > 0) begin
        m_cnt[c] = m_cnt[c] - 1;
        if (m_cnt[c] == 0) m_mask[c] = '0;
      end
`endif
      m_snap[c] = nv;
    end
  endtask

  task automatic set_ch(input int c, input logic [WIDTH-1:0] val);
    data[c*WIDTH +: WIDTH] = val;
  endtask

  // One pixel clock: drive at negedge, check the pixel issued two clocks earlier after posedge.
  task automatic step(input int h, input int v, input logic rst, input string tag,
                      input bit use_fixed = 1'b0, input logic [24:0] fixed = '0);
    logic [24:0] exp_v;
    string       t;
    @(negedge clk);
    reset       = rst;
    bus.vga_h   = h[10:0];
    bus.vga_v   = v[10:0];
    bus.data_in = data;
    if (rst) begin
      model_reset();
      if (expq.size() > 0) expq[expq.size()-1] = OFF;
      expq.push_back(OFF);
    end else begin
      if (h[10:0] == 11'd0 && v[10:0] == 11'd0) model_frame();
      expq.push_back((use_fixed && ANCHOR) ? fixed : model_pixel(int'(h[10:0]), int'(v[10:0])));
    end
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    if (expq.size() >= 2) begin
      exp_v = expq.pop_front();
      t     = tagq.pop_front();
      compared++;
      assert (bus.display_on === exp_v[24]) else begin
        mismatched++;
        $error("FAIL %s display_on got %0b want %0b", t, bus.display_on, exp_v[24]);
      end
      compared++;
      assert (bus.pixel_out === exp_v[23:0]) else begin
        mismatched++;
        $error("FAIL %s pixel_out got %06h want %06h", t, bus.pixel_out, exp_v[23:0]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    data        = '0;
    bus.data_in = '0;
    bus.vga_h   = '0;
    bus.vga_v   = '0;
    model_reset();

    // Reset held three clocks mid-frame, then live data that must not show before a frame start.
    data = 64'h1234_5678_9ABC_DEF0;
    repeat (3) step(60, 12, 1'b1, "reset", 1'b1, OFF);
    step(55, 12, 1'b0, "post_reset");
    step(250, 100, 1'b0, "post_reset_ch3");

    set_ch(0, 8'hA5);
    step(0, 0, 1'b0, "frame0");
    step(50, 10, 1'b0, "a5_msb", 1'b1, RED);
    step(70, 10, 1'b0, "a5_bit6", 1'b1, BLUE);
    step(190, 10, 1'b0, "a5_bit0", 1'b1, RED);

    for (int h = 48; h <= 68; h++) begin
      if (h < 50 || h > 65) step(h, 12, 1'b0, "sweep", 1'b1, OFF);
      else                  step(h, 12, 1'b0, "sweep", 1'b1, RED);
    end

    // Tear-free: a mid-frame change on ch1 waits for the next frame start.
    set_ch(1, 8'h00);
    step(0, 0, 1'b0, "frame_tf0");
    step(50, 40, 1'b0, "tf_before", 1'b1, BLUE);
    set_ch(1, 8'hFF);
    repeat (3) step(50, 40, 1'b0, "tf_hold", 1'b1, BLUE);
    step(0, 0, 1'b0, "frame_tf1");
    step(50, 40, 1'b0, "tf_after", 1'b1, RED);

    step(49, 10, 1'b0, "edge_l", 1'b1, OFF);
    step(50, 9, 1'b0, "edge_t", 1'b1, OFF);
    step(66, 10, 1'b0, "edge_r", 1'b1, OFF);
    step(50, 26, 1'b0, "edge_b", 1'b1, OFF);
    step(65, 25, 1'b0, "edge_in", 1'b1, RED);
    for (int v = 218; v <= 237; v++) step(50, v, 1'b0, "ch7_row");
    step(2047, 2047, 1'b0, "far", 1'b1, OFF);
    step(50, 2047, 1'b0, "far_v", 1'b1, OFF);
    step(2047, 10, 1'b0, "far_h", 1'b1, OFF);

    // Change highlight on ch0 bit 0, with a second change one frame later.
    set_ch(0, 8'h00);
    step(0, 0, 1'b0, "hl_pre");
    step(0, 0, 1'b0, "hl_pre2");
    step(0, 0, 1'b0, "hl_pre3");
    step(190, 10, 1'b0, "hl_base", 1'b1, BLUE);
    set_ch(0, 8'h01);
    for (int f = 0; f < 6; f++) begin
      if (f == 1) set_ch(0, 8'h03);
      step(0, 0, 1'b0, "hl_frame");
      step(190, 10, 1'b0, "hl_bit0", 1'b1, RED);
      step(170, 10, 1'b0, "hl_bit1", 1'b1, (f == 0) ? BLUE : RED);
    end

    for (int i = 0; i < 1500; i++) begin
      int h, v;
      bit rst;
      if ($urandom_range(0, 9) == 0)
        set_ch(int'($urandom_range(0, NUM_CH - 1)), WIDTH'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        h = 0;
        v = 0;
      end else if ($urandom_range(0, 19) == 0) begin
        h = int'($urandom_range(0, 2047));
        v = int'($urandom_range(0, 2047));
      end else begin
        h = int'($urandom_range(0, 240));
        v = int'($urandom_range(0, 260));
      end
      rst = ($urandom_range(0, 299) == 0);
      step(h, v, rst, "random");
    end

    step(0, 500, 1'b0, "flush");
    step(0, 500, 1'b0, "flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
